suite_rom_loader: RTL and testbench
===================================

Name: suite_rom_loader

Overview:
- Sequences ioctl downloads from the HPS into the suite core's pattern/asset memories.
- Sits in the sim/FPGA top, between the ioctl bus and the suite memory write ports.
- Holds the suite core in reset for the whole download and for a fixed tail afterwards.
- Buffers one write at a time and back-pressures the HPS via ioctl_wait.
- Produces a byte count and checksum for the bench and the OSD.

Parameters:
- ADDR_W, 17, width of the memory write address (one byte per address).
- REGION_BITS, 2, number of top address bits that select the target region; regions = 2**REGION_BITS.
- ROM_INDEX, 8'd0, the ioctl_index value this loader accepts.
- HOLD_CYCLES, 16, cycles core_reset stays high after the download ends; must be ≥1.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download window is active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  download index.
- ioctl_wait  out  1  back-pressure to the HPS.
- mem_addr  out  ADDR_W-REGION_BITS  address within the selected region.
- mem_data  out  8  write data.
- mem_we  out  1  write request; held until accepted.
- mem_sel  out  2**REGION_BITS  one-hot region select; valid while mem_we is high.
- mem_ready  in  1  target accepts the write this cycle.
- core_reset  out  1  reset to the suite core.
- byte_count  out  ADDR_W+1  number of bytes accepted this download.
- checksum  out  8  modulo-256 sum of the accepted bytes.
- load_error  out  1  sticky error flag.

Behaviour:
- Reset values:
  - state = IDLE; ioctl_wait = 0; mem_we = 0; mem_sel = 0; mem_addr = 0; mem_data = 0.
  - core_reset = 1; byte_count = 0; checksum = 0; load_error = 0.
  - The hold counter is loaded with HOLD_CYCLES, so core_reset falls after reset with no download.
- Active download: "active" means ioctl_download = 1 and ioctl_index = ROM_INDEX. Other indices are fully ignored: no writes, no wait, no reset.
- States:
  - IDLE → LOAD when active. On entry, clear byte_count, checksum and load_error, and set core_reset = 1.
  - LOAD:
    - ioctl_wr with ioctl_addr < 2**ADDR_W: capture the transfer into the buffer.
      - mem_sel = onehot(addr[ADDR_W-1 -: REGION_BITS]); mem_addr = low bits; mem_data = ioctl_dout.
      - mem_we = 1 and ioctl_wait = 1 on the next cycle; go to WRITE.
    - ioctl_wr with addr ≥ 2**ADDR_W: no write; set load_error; stay in LOAD.
    - !active with no pending write: go to HOLD.
  - WRITE: hold mem_we, mem_sel, mem_addr, mem_data and ioctl_wait stable until mem_ready = 1. In the cycle mem_ready = 1:
    - byte_count += 1; checksum += mem_data (8-bit wrap).
    - Next cycle: mem_we = 0, mem_sel = 0, ioctl_wait = 0; return to LOAD.
  - WRITE exceptions:
    - ioctl_wr arriving in WRITE is a protocol violation: the byte is dropped and load_error is set.
    - ioctl_download falling in WRITE: finish the pending write first, then go to HOLD.
  - HOLD: core_reset = 1; decrement the hold counter from HOLD_CYCLES. core_reset falls in the cycle after the count reaches 0; go to IDLE.
    - If active reasserts during HOLD, go straight to LOAD and clear the counters as on entry.
- Latency:
  - ioctl_wr to mem_we: 1 cycle.
  - Minimum write occupancy: 1 cycle if mem_ready is already high.
  - Back-to-back HPS strobes are therefore serviced once every 2 cycles, with ioctl_wait covering the gap.
- byte_count and checksum hold their values after the download until the next one starts.
- reset asserted mid-WRITE: the write is abandoned (mem_we = 0 next cycle) and all outputs take their reset values.

Decomposition:
- Package suite_loader_pkg holds:
  - the state enum: IDLE, LOAD, WRITE, HOLD;
  - the ROM_INDEX default;
  - a function onehot_region(addr_bits).
- One natural sub-module: suite_loader_holdoff, a loadable down-counter that generates core_reset from start/stop pulses. Everything else stays in suite_rom_loader.

Test Plan:
1. Reset release with no download → core_reset falls exactly HOLD_CYCLES+1 cycles after reset drops; ioctl_wait stays 0.
2. Download at index 0: bytes 0x01, 0x02, 0x03 to addresses 0x00000–0x00002, mem_ready tied high → three mem_we pulses with mem_sel = 4'b0001; byte_count = 3; checksum = 0x06; core_reset falls HOLD_CYCLES+1 cycles after ioctl_download drops.
3. Write to address 0x18004 with mem_ready low for 5 cycles → mem_sel = 4'b1000, mem_addr = 0x0004; ioctl_wait and mem_we high for 6 cycles; fields stable throughout; byte_count +1 only on the accept cycle.
4. Download at index 3 → no mem_we, ioctl_wait = 0, core_reset unchanged, counters unchanged.
5. Address 0x20000, then an ioctl_wr during WRITE → load_error = 1 (sticky until the next download); no write for either byte; byte_count counts only the valid bytes.
6. reset pulsed while mem_we is held and mem_ready is low → next cycle mem_we = 0, ioctl_wait = 0, core_reset = 1, byte_count = 0, checksum = 0, load_error = 0, state = IDLE.

Source files
------------

// File: rtl/suite_loader_pkg.sv
// Shared types and helpers for the suite ROM loader.
// State encoding, default download index and region decode.
package suite_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    HOLD
  } state_t;

  localparam logic [7:0] ROM_INDEX_DEF = 8'd0;

  function automatic logic [15:0] onehot_region(
    input logic [3:0] addr_bits
  );
    return 16'd1 << addr_bits;
  endfunction

endpackage

// File: rtl/suite_rom_loader_if.sv
// Suite memory write port: one buffered byte write
// held by the loader until the target accepts it.
interface suite_rom_loader_if #(
  parameter int ADDR_W      = 17,
  parameter int REGION_BITS = 2
);

  localparam int NREG = 2 ** REGION_BITS;
  localparam int AW   = ADDR_W - REGION_BITS;

  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_data;
  logic            mem_we;
  logic [NREG-1:0] mem_sel;
  logic            mem_ready;

  modport master (
    output mem_addr,
    output mem_data,
    output mem_we,
    output mem_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_data,
    input  mem_we,
    input  mem_sel,
    output mem_ready
  );

endinterface

// File: rtl/suite_loader_holdoff.sv
// Core reset hold-off: start pins core_reset high, stop
// begins a HOLD_CYCLES countdown after which it releases.
module suite_loader_holdoff #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic start,
  input  logic stop,
  output logic core_reset,
  output logic done
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          rst_q, rst_d;

  // The stop cycle itself is the first decrement.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    rst_d = rst_q;
    if (start) begin
      cnt_d = CW'(HOLD_CYCLES);
      run_d = 1'b0;
      rst_d = 1'b1;
    end else if (stop) begin
      cnt_d = CW'(HOLD_CYCLES - 1);
      run_d = 1'b1;
      rst_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
        rst_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= CW'(HOLD_CYCLES);
      run_q <= 1'b1;
      rst_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      rst_q <= rst_d;
    end
  end

  assign core_reset = rst_q;
  assign done       = run_q && (cnt_q == '0);

endmodule

// File: rtl/suite_rom_loader.sv
// Sequences ioctl downloads into the suite memories,
// one buffered write at a time, with core reset hold-off.
module suite_rom_loader
  import suite_loader_pkg::*;
#(
  parameter int         ADDR_W      = 17,
  parameter int         REGION_BITS = 2,
  parameter logic [7:0] ROM_INDEX   = ROM_INDEX_DEF,
  parameter int         HOLD_CYCLES = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic [7:0]          ioctl_index,
  output logic                ioctl_wait,
  suite_rom_loader_if.master  mem,
  output logic                core_reset,
  output logic [ADDR_W:0]     byte_count,
  output logic [7:0]          checksum,
  output logic                load_error
);

  localparam int NREG = 2 ** REGION_BITS;
  localparam int AW   = ADDR_W - REGION_BITS;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [7:0]      sum_q, sum_d;
  logic            err_q, err_d;

  logic active, in_range, start, stop, hold_done;

  assign active   = ioctl_download && (ioctl_index == ROM_INDEX);
  assign in_range = (ioctl_addr >> ADDR_W) == 25'd0;
  assign start    = active
                 && (state_q == IDLE || state_q == HOLD);
  assign stop     = (state_q == LOAD) && !active;

  suite_loader_holdoff #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_holdoff (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .core_reset(core_reset),
    .done      (hold_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (active) state_d = LOAD;
      LOAD: begin
        if (active && ioctl_wr && in_range)
          state_d = WRITE;
        else if (!active)
          state_d = HOLD;
      end
      WRITE: if (mem.mem_ready) state_d = LOAD;
      HOLD: begin
        if (active)
          state_d = LOAD;
        else if (hold_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    err_d  = err_q;
    if (start) begin
      cnt_d = '0;
      sum_d = '0;
      err_d = 1'b0;
    end
    if (state_q == LOAD && active && ioctl_wr) begin
      if (in_range) begin
        sel_d  = NREG'(onehot_region(
                   4'(ioctl_addr[ADDR_W-1 -: REGION_BITS])));
        addr_d = ioctl_addr[AW-1:0];
        data_d = ioctl_dout;
      end else begin
        err_d = 1'b1;
      end
    end
    if (state_q == WRITE) begin
      // The HPS ignored ioctl_wait; that byte is lost.
      if (ioctl_wr && active) err_d = 1'b1;
      if (mem.mem_ready) begin
        cnt_d = cnt_q + 1'b1;
        sum_d = sum_q + data_q;
      end
    end
  end

  always_comb begin
    mem.mem_we   = (state_q == WRITE);
    ioctl_wait   = (state_q == WRITE);
    mem.mem_sel  = (state_q == WRITE) ? sel_q : '0;
    mem.mem_addr = addr_q;
    mem.mem_data = data_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  assign byte_count = cnt_q;
  assign checksum   = sum_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_suite_rom_loader.sv
// Scoreboard bench for suite_rom_loader: expected writes
// are queued at the strobe and compared on accept.
module tb_suite_rom_loader;
  import suite_loader_pkg::*;

  localparam int HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic        core_reset;
  logic [17:0] byte_count;
  logic [7:0]  checksum;
  logic        load_error;

  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;
  logic [31:0] sb[$];

  suite_rom_loader_if #(.ADDR_W(17), .REGION_BITS(2)) mem_if ();

  suite_rom_loader #(
    .ADDR_W(17),
    .REGION_BITS(2),
    .ROM_INDEX(8'd0),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_index   (ioctl_index),
    .ioctl_wait    (ioctl_wait),
    .mem           (mem_if),
    .core_reset    (core_reset),
    .byte_count    (byte_count),
    .checksum      (checksum),
    .load_error    (load_error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] wr_word(input logic [24:0] a,
                                          input logic [7:0] d);
    logic [3:0] sel;
    sel = 4'b0001 << a[16:15];
    return {5'b0, sel, a[14:0], d};
  endfunction

  always @(negedge clk_sys) begin
    if (!reset && mem_if.mem_we && mem_if.mem_ready) begin
      n_acc++;
      if (sb.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        check("wr", {5'b0, mem_if.mem_sel, mem_if.mem_addr,
                     mem_if.mem_data}, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index = idx;
    tick();
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_free();
    int k = 0;
    while (ioctl_wait && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) check("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    sb.push_back(wr_word(a, d));
    strobe(a, d);
    wait_free();
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (core_reset && n < 60);
    check(tag, n, HOLD + 1);
  endtask

  task automatic end_dl(input string tag);
    ioctl_download = 1'b0;
    wait_release(tag);
  endtask

  initial begin
    int acc0;
    logic saw_wait;
    logic [31:0] exp_hold;
    mem_if.mem_ready = 1'b1;

    // Reset state and release with no download
    repeat (3) tick();
    check("rst_core_reset", core_reset, 1);
    check("rst_we_wait_sel", {mem_if.mem_we, ioctl_wait, mem_if.mem_sel}, 0);
    check("rst_addr_data", {mem_if.mem_addr, mem_if.mem_data}, 0);
    check("rst_counts", {byte_count, checksum, load_error}, 0);
    reset = 1'b0;
    begin
      int n = 0;
      saw_wait = 1'b0;
      do begin
        tick();
        n++;
        if (ioctl_wait) saw_wait = 1'b1;
      end while (core_reset && n < 60);
      check("boot_release", n, HOLD + 1);
      check("boot_wait", saw_wait, 0);
    end

    // Three bytes to region 0, ready tied high
    acc0 = n_acc;
    start_dl(8'd0);
    check("dl_core_reset", core_reset, 1);
    send(25'h00000, 8'h01);
    send(25'h00001, 8'h02);
    send(25'h00002, 8'h03);
    check("t2_pulses", n_acc - acc0, 3);
    check("t2_count", byte_count, 3);
    check("t2_sum", checksum, 8'h06);
    end_dl("t2_release");
    check("t2_count_held", byte_count, 3);

    // Stalled write into region 3
    start_dl(8'd0);
    check("t3_count_clear", byte_count, 0);
    mem_if.mem_ready = 1'b0;
    sb.push_back(wr_word(25'h18004, 8'hA5));
    strobe(25'h18004, 8'hA5);
    exp_hold = {3'b0, 1'b1, 1'b1, 4'b1000, 15'h0004, 8'hA5};
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) mem_if.mem_ready = 1'b1;
      check("t3_hold", {3'b0, mem_if.mem_we, ioctl_wait,
                        mem_if.mem_sel, mem_if.mem_addr,
                        mem_if.mem_data}, exp_hold);
      check("t3_count_wait", byte_count, 0);
      tick();
    end
    check("t3_done", {mem_if.mem_we, ioctl_wait, mem_if.mem_sel}, 0);
    check("t3_count", byte_count, 1);
    check("t3_sum", checksum, 8'hA5);
    end_dl("t3_release");

    // Foreign index is ignored
    start_dl(8'd3);
    strobe(25'h00000, 8'h55);
    for (int k = 0; k < 3; k++) begin
      check("t4_quiet", {mem_if.mem_we, ioctl_wait, core_reset}, 0);
      check("t4_counts", {byte_count, checksum}, {18'd1, 8'hA5});
      tick();
    end
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    tick();

    // Out-of-range address
    start_dl(8'd0);
    send(25'h00010, 8'h10);
    strobe(25'h20000, 8'h77);
    check("t5_range_err", load_error, 1);
    check("t5_range_nowe", {mem_if.mem_we, ioctl_wait}, 0);
    check("t5_count", {byte_count, checksum}, {18'd1, 8'h10});
    end_dl("t5_release");
    check("t5_sticky", load_error, 1);

    // Strobe while a write is pending
    start_dl(8'd0);
    check("t5b_err_clear", load_error, 0);
    mem_if.mem_ready = 1'b0;
    sb.push_back(wr_word(25'h00005, 8'h20));
    strobe(25'h00005, 8'h20);
    strobe(25'h00006, 8'h99);
    check("t5b_viol_err", load_error, 1);
    check("t5b_buf_kept", {mem_if.mem_we, mem_if.mem_addr,
                           mem_if.mem_data}, {1'b1, 15'h0005, 8'h20});
    mem_if.mem_ready = 1'b1;
    wait_free();
    check("t5b_count", {byte_count, checksum}, {18'd1, 8'h20});
    end_dl("t5b_release");

    // Reset while a write is stalled
    start_dl(8'd0);
    send(25'h00001, 8'h11);
    strobe(25'h20001, 8'h00);
    mem_if.mem_ready = 1'b0;
    strobe(25'h08000, 8'h42);
    check("t6_pending", {mem_if.mem_we, load_error}, 2'b11);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    check("t6_we_wait", {mem_if.mem_we, ioctl_wait, mem_if.mem_sel}, 0);
    check("t6_core_reset", core_reset, 1);
    check("t6_counts", {byte_count, checksum, load_error}, 0);
    check("t6_addr_data", {mem_if.mem_addr, mem_if.mem_data}, 0);
    check("t6_state", dut.state_q, IDLE);
    reset = 1'b0;
    mem_if.mem_ready = 1'b1;
    wait_release("t6_release");

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
